// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit: op codes,
// FSM states, datapath mode and the WIDTH legality check.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIXUP,
        S_DONE
    } state_e;

    typedef enum logic {
        MODE_MUL,
        MODE_DIV
    } mode_e;

    function automatic bit muldiv_width_ok(input int w);
        return (w >= 4) && ((w % 2) == 0);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract
// for divide. acc = {partial (WIDTH+1), multiplier/quotient (WIDTH)}.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0]  acc,
    input  logic [WIDTH-1:0]  operand,
    input  mode_e             mode,
    output logic [2*WIDTH:0]  acc_next,
    output logic              q_bit
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] rem_next;

    // The remainder never exceeds the divisor, so only its low WIDTH bits are shifted up.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        q_bit    = 1'b0;
        rem_next = shifted;
        acc_next = {1'b0, sum, acc[WIDTH-1:1]};
        if (mode == MODE_DIV) begin
            q_bit    = (shifted >= {1'b0, operand});
            rem_next = q_bit ? (shifted - {1'b0, operand}) : shifted;
            acc_next = {rem_next, acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Optional feature: define MULDIV_DIVZERO_EN to add the div_zero flag output.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
`ifdef MULDIV_DIVZERO_EN
    ,
    output logic             div_zero
`endif
);

    if (!muldiv_width_ok(WIDTH)) begin : g_bad_width
        $error("muldiv_seq: WIDTH must be >= 4 and even");
    end

    state_e state, state_next;

    logic [CNT_W-1:0] cnt;
    logic [2*WIDTH:0] acc, step_acc;
    logic             step_q;
    mode_e            step_mode;
    logic [WIDTH-1:0] y_mag, x_raw;
    logic             is_div, neg_main, neg_rem, y_zero;

    logic             accept_arith, accept_move, is_signed_op, x_neg, y_neg;
    logic [WIDTH-1:0] x_mag, y_mag_in;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0] hi_fix, lo_fix;

    assign accept_arith = (state == S_IDLE) && start &&
                          ((op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU));
    assign accept_move  = (state == S_IDLE) && start && ((op == OP_MTHI) || (op == OP_MTLO));
    assign is_signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign x_neg        = is_signed_op && X[WIDTH-1];
    assign y_neg        = is_signed_op && Y[WIDTH-1];
    assign x_mag        = x_neg ? -X : X;
    assign y_mag_in     = y_neg ? -Y : Y;
    assign step_mode    = is_div ? MODE_DIV : MODE_MUL;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .operand  (y_mag),
        .mode     (step_mode),
        .acc_next (step_acc),
        .q_bit    (step_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept_arith)     state_next = S_CALC;
                else if (accept_move) state_next = S_DONE;
            end
            S_CALC: begin
                busy = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) state_next = S_FIXUP;
            end
            S_FIXUP: begin
                busy       = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Divide by zero bypasses sign fixup and reports the raw dividend in HI.
    always_comb begin
        product = acc[2*WIDTH-1:0];
        hi_fix  = '0;
        lo_fix  = '0;
        if (!is_div) begin
            if (neg_main) product = -acc[2*WIDTH-1:0];
            hi_fix = product[2*WIDTH-1:WIDTH];
            lo_fix = product[WIDTH-1:0];
        end else if (y_zero) begin
            hi_fix = x_raw;
            lo_fix = '1;
        end else begin
            hi_fix = neg_rem  ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            lo_fix = neg_main ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            y_mag    <= '0;
            x_raw    <= '0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            y_zero   <= 1'b0;
            HI       <= '0;
            LO       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept_arith) begin
                        cnt      <= '0;
                        acc      <= {{(WIDTH+1){1'b0}}, x_mag};
                        y_mag    <= y_mag_in;
                        x_raw    <= X;
                        is_div   <= (op == OP_DIV) || (op == OP_DIVU);
                        neg_main <= x_neg ^ y_neg;
                        neg_rem  <= x_neg;
                        y_zero   <= (Y == '0);
                    end else if (accept_move) begin
                        if (op == OP_MTHI) HI <= X;
                        else               LO <= X;
                    end
                end
                S_CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    acc <= step_acc | {{(2*WIDTH){1'b0}}, step_q};
                end
                S_FIXUP: begin
                    HI <= hi_fix;
                    LO <= lo_fix;
                end
                default: ;
            endcase
        end
    end

`ifdef MULDIV_DIVZERO_EN
    always_ff @(posedge clk) begin
        if (!rst_n)                           div_zero <= 1'b0;
        else if (accept_arith || accept_move) div_zero <= 1'b0;
        else if (state == S_FIXUP)            div_zero <= is_div && y_zero;
    end
`endif

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed and random ops against a plain-arithmetic model.
module tb_muldiv_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] X = '0;
    logic [W-1:0] Y = '0;
    logic         busy, done;
    logic [W-1:0] HI, LO;
`ifdef MULDIV_DIVZERO_EN
    logic         div_zero;
`endif

    muldiv_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .X        (X),
        .Y        (Y),
        .busy     (busy),
        .done     (done),
        .HI       (HI),
        .LO       (LO)
`ifdef MULDIV_DIVZERO_EN
        ,
        .div_zero (div_zero)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
        int           busy_len;
        logic         dz;
    } exp_t;

    exp_t         sb[$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           busy_run = 0;
    logic [W-1:0] mhi = '0, mlo = '0;
    logic [W-1:0] prev_hi = '0, prev_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Reference results straight from integer arithmetic on the operands.
    task automatic ref_model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                             output logic [W-1:0] h, output logic [W-1:0] l, output logic dz);
        longint       sx, sy, q, r;
        logic [63:0]  p, qv, rv;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        h  = mhi;
        l  = mlo;
        dz = 1'b0;
        case (o)
            3'd0: begin p = sx * sy; h = p[63:32]; l = p[31:0]; end
            3'd1: begin p = {32'b0, x} * {32'b0, y}; h = p[63:32]; l = p[31:0]; end
            3'd2, 3'd3: begin
                if (y == '0) begin
                    h = x; l = '1; dz = 1'b1;
                end else if (o == 3'd2) begin
                    q = sx / sy; r = sx % sy; qv = q; rv = r;
                    h = rv[31:0]; l = qv[31:0];
                end else begin
                    h = x % y; l = x / y;
                end
            end
            3'd4: h = x;
            3'd5: l = x;
            default: ;
        endcase
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit expect_result);
        exp_t         e;
        logic [W-1:0] h, l;
        logic         dz;
        int           c1;
        @(negedge clk);
        op = o; X = x; Y = y; start = 1'b1;
        @(posedge clk);
        #1;
        c1 = cyc;
        start = 1'b0;
        if (expect_result && o <= 3'd5) begin
            ref_model(o, x, y, h, l, dz);
            prev_hi = mhi; prev_lo = mlo;
            mhi = h; mlo = l;
            e.hi = h; e.lo = l; e.dz = dz;
            e.cyc      = (o <= 3'd3) ? c1 + W + 1 : c1;
            e.busy_len = (o <= 3'd3) ? W + 1 : 0;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (busy) begin
                check("hold_hi", HI, prev_hi);
                check("hold_lo", LO, prev_lo);
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_timeout", {63'b0, seen}, 64'd1);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return '1;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every done pulse pops one expectation and compares result, timing and busy length.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", {63'b0, done}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("hi", HI, e.hi);
                    check("lo", LO, e.lo);
                    check("done_cycle", cyc, e.cyc);
                    check("busy_len", busy_run, e.busy_len);
                    check("busy_in_done", {63'b0, busy}, 64'd0);
`ifdef MULDIV_DIVZERO_EN
                    check("div_zero", {63'b0, div_zero}, {63'b0, e.dz});
`endif
                end
                busy_run = 0;
            end
        end
    end

    initial begin
        logic [2:0]   o;
        logic [W-1:0] x, y;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hi", HI, 0);
        check("rst_lo", LO, 0);
        check("rst_busy", {63'b0, busy}, 0);
        check("rst_done", {63'b0, done}, 0);
`ifdef MULDIV_DIVZERO_EN
        check("rst_div_zero", {63'b0, div_zero}, 0);
`endif
        rst_n = 1'b1;

        issue(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b1);          wait_done(60);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);  wait_done(60);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);          wait_done(60);
        issue(3'd3, 32'd100, 32'd7, 1'b1);                wait_done(60);
        issue(3'd3, 32'd100, 32'd0, 1'b1);                wait_done(60);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);  wait_done(60);
        issue(3'd2, 32'hFFFF_FFF0, 32'd0, 1'b1);          wait_done(60);
        issue(3'd4, 32'h0000_ABCD, 32'd0, 1'b1);          wait_done(10);
        issue(3'd5, 32'h1357_9BDF, 32'd0, 1'b1);          wait_done(10);

        // A move presented mid-multiply must be ignored.
        issue(3'd0, 32'd12345, 32'd678, 1'b1);
        repeat (3) @(posedge clk);
        issue(3'd4, 32'h0000_1234, 32'd0, 1'b0);
        wait_done(60);
        repeat (2) @(negedge clk);
        check("mthi_ignored_hi", HI, mhi);

        issue(3'd6, 32'h55, 32'h66, 1'b0);
        repeat (5) @(negedge clk);
        check("noop_busy", {63'b0, busy}, 0);
        check("noop_hi", HI, mhi);
        check("noop_lo", LO, mlo);

        // Reset ten cycles into a multiply aborts it with no done pulse.
        issue(3'd0, 32'd7, 32'd9, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("abort_hi", HI, 0);
        check("abort_lo", LO, 0);
        check("abort_busy", {63'b0, busy}, 0);
        mhi = '0; mlo = '0;
        repeat (40) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            x = pick();
            y = pick();
            if (o <= 3'd5) begin
                issue(o, x, y, 1'b1);
                wait_done(60);
            end else begin
                issue(o, x, y, 1'b0);
                repeat (3) @(negedge clk);
            end
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
